// File: rtl/keypad_controller.sv
// 4x4 keypad scanner: row sequencing, column synchronizing/debouncing, hex decode
// and a two-deep history of accepted keys for a dual 7-segment display.
module keypad_controller #(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols_raw,
    output logic [3:0] rows,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld,
        StRelease
    } state_e;

    state_e          r_state;
    logic [3:0]      r_sync1;
    logic [3:0]      r_sync2;
    logic [3:0]      r_rows;
    logic [3:0]      r_col;
    logic [DivW-1:0] r_div;
    logic [CntW-1:0] r_cnt;
    logic            r_key_valid;
    logic [3:0]      r_key_code;
    logic [3:0]      r_digit_new;
    logic [3:0]      r_digit_old;

    logic            w_onehot;
    logic            w_col_hit;
    logic [3:0]      w_rows_next;
    logic [3:0]      w_key;

    assign w_onehot    = (r_sync2 != 4'b0) && ((r_sync2 & (r_sync2 - 4'd1)) == 4'b0);
    assign w_col_hit   = |(r_sync2 & r_col);
    assign w_rows_next = {r_rows[0], r_rows[3:1]};

    always_comb begin
        w_key = 4'h0;
        case ({r_rows, r_col})
            8'b1000_1000: w_key = 4'h1;
            8'b1000_0100: w_key = 4'h2;
            8'b1000_0010: w_key = 4'h3;
            8'b1000_0001: w_key = 4'hA;
            8'b0100_1000: w_key = 4'h4;
            8'b0100_0100: w_key = 4'h5;
            8'b0100_0010: w_key = 4'h6;
            8'b0100_0001: w_key = 4'hB;
            8'b0010_1000: w_key = 4'h7;
            8'b0010_0100: w_key = 4'h8;
            8'b0010_0010: w_key = 4'h9;
            8'b0010_0001: w_key = 4'hC;
            8'b0001_1000: w_key = 4'hE;
            8'b0001_0100: w_key = 4'h0;
            8'b0001_0010: w_key = 4'hF;
            8'b0001_0001: w_key = 4'hD;
            default:      w_key = 4'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= StScan;
            r_sync1     <= 4'b0;
            r_sync2     <= 4'b0;
            r_rows      <= 4'b1000;
            r_col       <= 4'b0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= 4'h0;
            r_digit_new <= 4'h0;
            r_digit_old <= 4'h0;
        end else begin
            r_sync1     <= cols_raw;
            r_sync2     <= r_sync1;
            r_key_valid <= 1'b0;
            case (r_state)
                StScan: begin
                    // Sample on the last dwell cycle so the synchronizer has settled.
                    if (r_div == DivLast) begin
                        r_div <= '0;
                        if (w_onehot) begin
                            r_col   <= r_sync2;
                            r_cnt   <= '0;
                            r_state <= StDebounce;
                        end else begin
                            r_rows <= w_rows_next;
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                StDebounce: begin
                    if (r_cnt == CntMax) begin
                        r_key_valid <= 1'b1;
                        r_key_code  <= w_key;
                        r_digit_old <= r_digit_new;
                        r_digit_new <= w_key;
                        r_state     <= StHeld;
                    end else if (r_sync2 == r_col) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_div   <= '0;
                        r_state <= StScan;
                    end
                end
                StHeld: begin
                    if (!w_col_hit) begin
                        r_cnt   <= '0;
                        r_state <= StRelease;
                    end
                end
                StRelease: begin
                    if (w_col_hit) begin
                        r_state <= StHeld;
                    end else if (r_cnt == CntMax) begin
                        r_div   <= '0;
                        r_rows  <= w_rows_next;
                        r_state <= StScan;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StScan;
            endcase
        end
    end

    assign rows      = r_rows;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign digit_new = r_digit_new;
    assign digit_old = r_digit_old;

endmodule
